// File: rtl/coverage_map_gen.sv
// rtl/coverage_map_gen.sv - multi-circle grid occupancy bitmap builder
//
// Purpose: scans one (channel, row) pair per cycle and accumulates each
// enabled circle's row mask into a GRID_W x GRID_H bitmap, combining the
// channels as a union (mode 0) or an intersection (mode 1).
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - request a new map (honoured only when idle or done)
//   ch_x   - packed column centres, channel k at [k*COORD_W +: COORD_W]
//   ch_y   - packed row centres, same packing
//   ch_r   - packed radii, same packing
//   ch_en  - per-channel enable
//   mode   - 0 = union, 1 = intersection
//   busy   - high while scanning
//   done   - high while map holds a completed result
//   map    - result bitmap, bit j*GRID_W+i is column i, row j
module coverage_map_gen #(
   parameter int GRID_W  = 8,
   parameter int GRID_H  = 8,
   parameter int COORD_W = 4,
   parameter int NUM_CH  = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [NUM_CH*COORD_W-1:0]   ch_x,
   input  logic [NUM_CH*COORD_W-1:0]   ch_y,
   input  logic [NUM_CH*COORD_W-1:0]   ch_r,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic                        mode,
   output logic                        busy,
   output logic                        done,
   output logic [GRID_W*GRID_H-1:0]    map
);

   localparam int DW  = COORD_W + 2;
   localparam int SW  = 2 * COORD_W + 4;
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int RW  = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam int MW  = GRID_W * GRID_H;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                      state_q;
   logic [CHW-1:0]              ch_q;
   logic [RW-1:0]               row_q;
   logic [NUM_CH*COORD_W-1:0]   x_q, y_q, r_q;
   logic [NUM_CH-1:0]           en_q;
   logic                        mode_q;
   logic [MW-1:0]               acc_q, acc_d;
   logic [COORD_W-1:0]          cx, cy, cr;
   logic [GRID_W-1:0]           acc_row, mask;
   logic                        last_step;

   // Row mask for one circle: column i set iff (i-x)^2 + (row-y)^2 <= r^2.
   // Differences are widened before squaring so nothing is truncated.
   function automatic logic [GRID_W-1:0] row_mask(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y,
      input logic [COORD_W-1:0] r,
      input logic [RW-1:0]      row
   );
      logic signed [DW-1:0] dx, dy;
      logic signed [SW-1:0] dxs, dys;
      logic [SW-1:0]        d2, r2;
      logic [GRID_W-1:0]    m;
      m   = '0;
      dy  = $signed(DW'(row)) - $signed({2'b00, y});
      dys = SW'(dy);
      r2  = SW'(r) * SW'(r);
      for (int i = 0; i < GRID_W; i++) begin
         dx  = $signed(DW'(i)) - $signed({2'b00, x});
         dxs = SW'(dx);
         d2  = $unsigned(dxs * dxs) + $unsigned(dys * dys);
         m[i] = (d2 <= r2);
      end
      return m;
   endfunction

   assign cx        = x_q[ch_q*COORD_W +: COORD_W];
   assign cy        = y_q[ch_q*COORD_W +: COORD_W];
   assign cr        = r_q[ch_q*COORD_W +: COORD_W];
   assign last_step = (ch_q == CHW'(NUM_CH - 1)) && (row_q == RW'(GRID_H - 1));

   always_comb begin
      acc_row = acc_q[row_q*GRID_W +: GRID_W];
      mask    = row_mask(cx, cy, cr, row_q);
      acc_d   = acc_q;
      // Disabled channels still take their rows of time but leave acc alone.
      if (en_q[ch_q]) begin
         acc_d[row_q*GRID_W +: GRID_W] = mode_q ? (acc_row & mask) : (acc_row | mask);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         row_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         r_q     <= '0;
         en_q    <= '0;
         mode_q  <= 1'b0;
         acc_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         map     <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  x_q     <= ch_x;
                  y_q     <= ch_y;
                  r_q     <= ch_r;
                  en_q    <= ch_en;
                  mode_q  <= mode;
                  acc_q   <= {MW{mode}};
                  ch_q    <= '0;
                  row_q   <= '0;
                  state_q <= S_SCAN;
                  busy    <= 1'b1;
                  done    <= 1'b0;
               end
            end
            S_SCAN: begin
               acc_q <= acc_d;
               if (last_step) begin
                  // With no channel enabled an intersection would stay all-1s;
                  // an empty map is the meaningful answer in both modes.
                  map     <= (|en_q) ? acc_d : '0;
                  ch_q    <= '0;
                  row_q   <= '0;
                  state_q <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else if (row_q == RW'(GRID_H - 1)) begin
                  row_q <= '0;
                  ch_q  <= ch_q + CHW'(1);
               end else begin
                  row_q <= row_q + RW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coverage_map_gen.sv
// tb/tb_coverage_map_gen.sv - scoreboard bench for coverage_map_gen
module tb_coverage_map_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] ch_x, ch_y, ch_r;
   logic [3:0]  ch_en;
   logic        mode;
   logic        busy, done;
   logic [63:0] map;

   int          n_checks = 0;
   int          n_bad    = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_prev = '0;

   coverage_map_gen #(
      .GRID_W(8), .GRID_H(8), .COORD_W(4), .NUM_CH(4)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .ch_x(ch_x), .ch_y(ch_y), .ch_r(ch_r), .ch_en(ch_en), .mode(mode),
      .busy(busy), .done(done), .map(map)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] r, input logic [3:0] en,
                                         input logic m);
      logic [63:0] res;
      logic        cov, any, hit;
      int          dx, dy, xk, yk, rk;
      res = '0;
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 8; i++) begin
            cov = m;
            any = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (en[k]) begin
                  xk  = int'(x[k*4 +: 4]);
                  yk  = int'(y[k*4 +: 4]);
                  rk  = int'(r[k*4 +: 4]);
                  dx  = i - xk;
                  dy  = j - yk;
                  hit = (dx*dx + dy*dy) <= rk*rk;
                  any = 1'b1;
                  cov = m ? (cov & hit) : (cov | hit);
               end
            end
            res[j*8 + i] = any & cov;
         end
      end
      return res;
   endfunction

   // Launch one map, then follow it to completion. poke pulses start and
   // scrambles the inputs mid-scan; neither may disturb the run.
   task automatic do_run(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] r, input logic [3:0] en, input logic m,
                         input bit poke);
      int    cyc, busy_cnt;
      logic  was_done;
      was_done = done;
      ch_x = x; ch_y = y; ch_r = r; ch_en = en; mode = m;
      exp_q.push_back(model(x, y, r, en, m));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (was_done) begin
         check_val({tag, "_restart_done"}, {63'd0, done}, 64'd0);
         check_val({tag, "_map_hold"}, map, exp_prev);
      end
      cyc = 0;
      busy_cnt = 0;
      while (!done && cyc < 200) begin
         if (busy) busy_cnt++;
         if (poke && cyc == 5) begin
            start = 1'b1;
            ch_x = $urandom; ch_y = $urandom; ch_r = $urandom;
            ch_en = $urandom; mode = ~m;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
      check_val({tag, "_done_latency"}, 64'(cyc), 64'd32);
      check_val({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
         exp_prev = exp_q.pop_front();
         check_val({tag, "_map"}, map, exp_prev);
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      ch_x = '0; ch_y = '0; ch_r = '0; ch_en = '0; mode = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check_val("rst_map", map, 64'd0);
      check_val("rst_done", {63'd0, done}, 64'd0);
      check_val("rst_busy", {63'd0, busy}, 64'd0);

      do_run("single", 16'h0003, 16'h0003, 16'h0001, 4'b0001, 1'b0, 1'b1);
      do_run("corners", 16'h0070, 16'h0070, 16'h0000, 4'b0011, 1'b0, 1'b0);
      do_run("inter", 16'h0042, 16'h0022, 16'h0022, 4'b0011, 1'b1, 1'b0);
      do_run("full", 16'h0003, 16'h0003, 16'h000F, 4'b0001, 1'b0, 1'b0);
      do_run("offgrid", 16'h000F, 16'h000F, 16'h0002, 4'b0001, 1'b0, 1'b0);
      do_run("noen", 16'h1234, 16'h4321, 16'h5555, 4'b0000, 1'b1, 1'b0);

      // Restart from DONE then reset mid-scan.
      ch_x = 16'h0044; ch_y = 16'h0044; ch_r = 16'h0033; ch_en = 4'b0011; mode = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("rr_done_drop", {63'd0, done}, 64'd0);
      check_val("rr_map_hold", map, exp_prev);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_val("rr_map", map, 64'd0);
      check_val("rr_busy", {63'd0, busy}, 64'd0);
      check_val("rr_done", {63'd0, done}, 64'd0);
      exp_prev = '0;
      @(negedge clk);
      check_val("rr_idle_busy", {63'd0, busy}, 64'd0);

      do_run("post_rst", 16'h0025, 16'h0061, 16'h0023, 4'b0011, 1'b0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         do_run("rand", 16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h7777)),
                4'($urandom), 1'($urandom), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
